// File: rtl/fp_div_pkg.sv
// Shared types and sizing helpers for the fp divider issue/collect block.
package fp_div_pkg;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int fp_dw(input int sig_width, input int exp_width);
    return sig_width + exp_width + 1;
  endfunction

  // Credits count 0..depth inclusive, hence depth+1 distinct values.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fp_div_result_fifo.sv
// Synchronous result FIFO with fall-through head; push and pop may coincide.
module fp_div_result_fifo
  import fp_div_pkg::*;
#(
  parameter int DW    = fp_dw(23, 8),
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          do_push;
  logic          do_pop;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fp_div_issue_collect.sv
// Streams one vector through a fixed-latency divider against a per-vector divisor
// and collects quotients into a credit-protected result FIFO.
module fp_div_issue_collect
  import fp_div_pkg::*;
#(
  parameter int SIG_WIDTH   = 23,
  parameter int EXP_WIDTH   = 8,
  parameter int DIV_LATENCY = 5,
  parameter int FIFO_DEPTH  = 8,
  parameter int LEN_W       = 8,
  localparam int DW         = fp_dw(SIG_WIDTH, EXP_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [DW-1:0]    cfg_divisor,
  output logic             busy,
  output logic             done,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    div_a,
  output logic [DW-1:0]    div_b,
  output logic             div_ab_valid,
  input  logic [DW-1:0]    div_z,
  input  logic             div_z_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int CW = cred_w(FIFO_DEPTH);
  localparam int FW = $clog2(DIV_LATENCY + 2);

  state_t           state_reg;
  logic [FW-1:0]    flush_cnt_reg;
  logic [CW-1:0]    credits_reg;
  logic [LEN_W-1:0] issue_rem_reg;
  logic [LEN_W-1:0] recv_rem_reg;
  logic [LEN_W-1:0] pop_rem_reg;
  logic [DW-1:0]    divisor_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             accept;
  logic             pop;
  logic             collect;
  logic             last_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_head;

  // in_ready depends only on state and counters so the producer may wait on it.
  assign in_ready  = (state_reg == RUN) && (issue_rem_reg != '0) && (credits_reg != '0);
  assign accept    = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign collect   = div_z_valid & (state_reg != FLUSH);
  assign last_pop  = pop && (pop_rem_reg == LEN_W'(1));
  assign out_last  = out_valid && (pop_rem_reg == LEN_W'(1));
  assign out_data  = out_valid ? fifo_head : '0;
  assign busy      = busy_reg;
  assign done      = done_reg;

  fp_div_result_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (collect),
    .push_data (div_z),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FLUSH;
      flush_cnt_reg <= FW'(DIV_LATENCY + 1);
      credits_reg   <= CW'(FIFO_DEPTH);
      issue_rem_reg <= '0;
      recv_rem_reg  <= '0;
      pop_rem_reg   <= '0;
      divisor_reg   <= '0;
      div_a         <= '0;
      div_b         <= '0;
      div_ab_valid  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      div_ab_valid <= accept;
      if (accept) begin
        div_a         <= in_data;
        div_b         <= divisor_reg;
        issue_rem_reg <= issue_rem_reg - LEN_W'(1);
      end
      if (collect) recv_rem_reg <= recv_rem_reg - LEN_W'(1);
      if (pop)     pop_rem_reg  <= pop_rem_reg - LEN_W'(1);
      if (accept && !pop) begin
        credits_reg <= credits_reg - CW'(1);
      end else if (pop && !accept) begin
        credits_reg <= credits_reg + CW'(1);
      end

      case (state_reg)
        FLUSH: begin
          // Results of ops issued before reset surface during this window and are dropped.
          busy_reg <= (flush_cnt_reg != '0);
          if (flush_cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - FW'(1);
          end
        end
        IDLE: begin
          busy_reg <= 1'b0;
          if (cfg_start) begin
            if (cfg_len != '0) begin
              divisor_reg   <= cfg_divisor;
              issue_rem_reg <= cfg_len;
              recv_rem_reg  <= cfg_len;
              pop_rem_reg   <= cfg_len;
              state_reg     <= RUN;
              busy_reg      <= 1'b1;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          busy_reg <= 1'b1;
          if (issue_rem_reg == '0) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (last_pop || (pop_rem_reg == '0)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            busy_reg <= 1'b1;
          end
        end
        default: state_reg <= FLUSH;
      endcase
    end
  end

  // A result with nothing outstanding, or one arriving at a full FIFO, means the
  // credit bookkeeping or the divider latency assumption is broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(collect && (recv_rem_reg == '0)));
      assert (!(collect && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_fp_div_issue_collect.sv
// Directed bench: divider modelled as a DIV_LATENCY delay line doing real division.
module tb_fp_div_issue_collect;

  localparam int L     = 5;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic [31:0] cfg_divisor = '0;
  logic        busy, done;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] div_a, div_b;
  logic        div_ab_valid;
  logic [31:0] div_z;
  logic        div_z_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fed = 0;
  int tot_acc = 0, tot_pop = 0, cred_base = 0;
  int ab_cnt = 0, done_cnt = 0, done_cyc = 0, done_base = 0;
  logic cred_chk = 1'b0;
  logic toggle = 1'b0;

  logic [31:0] din [64];
  logic [31:0] exp_data [64];
  logic [31:0] got_data [$];
  logic        got_last [$];
  int          pop_cyc [$];
  int          acc_cyc [$];
  logic [32:0] pipe [L];

  fp_div_issue_collect dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_len      (cfg_len),
    .cfg_divisor  (cfg_divisor),
    .busy         (busy),
    .done         (done),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_ab_valid (div_ab_valid),
    .div_z        (div_z),
    .div_z_valid  (div_z_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int ex;
    if (r == 0.0) return 32'h0;
    b  = $realtobits(r);
    ex = int'(b[62:52]) - 896;
    return {b[63], ex[7:0], b[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    int ex;
    if (f[30:0] == 31'h0) return 0.0;
    ex = int'(f[30:23]) + 896;
    b  = {f[31], ex[10:0], f[22:0], 29'h0};
    return $bitstoreal(b);
  endfunction

  assign div_z_valid = pipe[L-1][32];
  assign div_z       = pipe[L-1][31:0];

  initial begin
    for (int i = 0; i < L; i++) pipe[i] = '0;
    forever begin
      @(posedge clk);
      pipe[0] <= {div_ab_valid, div_ab_valid ? r2f(f2r(div_a) / f2r(div_b)) : 32'h0};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Monitor: handshakes, pops and done pulses, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (cred_chk)
      chk("credits", 64'(dut.credits_reg), 64'(DEPTH - ((tot_acc - tot_pop) - cred_base)));
    if (in_valid && in_ready) begin
      tot_acc++;
      acc_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      tot_pop++;
      got_data.push_back(out_data);
      got_last.push_back(out_last);
      pop_cyc.push_back(cyc);
    end
    if (div_ab_valid) ab_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) out_ready = ~out_ready;
  endtask

  task automatic clear();
    got_data.delete();
    got_last.delete();
    pop_cyc.delete();
    acc_cyc.delete();
    done_base = done_cnt;
    fed = 0;
  endtask

  task automatic start_vec(input int len, input logic [31:0] divisor);
    cfg_len     = 8'(len);
    cfg_divisor = divisor;
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic feed(input int upto, input int max_cyc);
    logic acc;
    for (int c = 0; c < max_cyc && fed < upto; c++) begin
      in_valid = 1'b1;
      in_data  = din[fed];
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) fed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int c = 0; c < max_cyc && done_cnt == done_base; c++) tick();
    repeat (3) tick();
    chk({tag, "_done_count"}, 64'(done_cnt - done_base), 64'(1));
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  task automatic check_results(input string tag, input int n);
    chk({tag, "_count"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
      chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    int t0;
    int ab_base;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_ab_valid", 64'(div_ab_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    rst = 1'b0;
    tick();
    tick();
    chk("flush_busy", 64'(busy), 64'(1));
    repeat (9) tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // Back-to-back: 2,4,6,8 / 2.0 -> 1,2,3,4
    clear();
    din[0] = 32'h40000000; din[1] = 32'h40800000;
    din[2] = 32'h40C00000; din[3] = 32'h41000000;
    exp_data[0] = 32'h3F800000; exp_data[1] = 32'h40000000;
    exp_data[2] = 32'h40400000; exp_data[3] = 32'h40800000;
    start_vec(4, 32'h40000000);
    feed(4, 20);
    wait_done("b2b", 40);
    check_results("b2b", 4);
    if (acc_cyc.size() == 4 && pop_cyc.size() == 4) begin
      t0 = acc_cyc[0];
      chk("b2b_accept_span", 64'(acc_cyc[3] - t0), 64'(3));
      for (int i = 0; i < 4; i++)
        chk($sformatf("b2b_pop_cycle%0d", i), 64'(pop_cyc[i] - t0), 64'(7 + i));
      chk("b2b_done_cycle", 64'(done_cyc - t0), 64'(11));
    end else begin
      chk("b2b_handshake_count", 64'(acc_cyc.size() + pop_cyc.size()), 64'(8));
    end

    // cfg_start during RUN/DRAIN must not disturb len or divisor
    clear();
    din[0] = 32'h40800000; din[1] = 32'h41000000;
    din[2] = 32'h41400000; din[3] = 32'h41800000;
    start_vec(4, 32'h40800000);
    cfg_start = 1'b1; cfg_len = 8'd1; cfg_divisor = 32'h3F800000;
    feed(4, 20);
    chk("ign_busy_run", 64'(busy), 64'(1));
    cfg_start = 1'b0;
    wait_done("ign", 40);
    check_results("ign", 4);

    // Zero length
    clear();
    ab_base = ab_cnt;
    cfg_len = 8'd0; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("zero_done_pulse", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    tick();
    chk("zero_done_clear", 64'(done), 64'(0));
    chk("zero_busy2", 64'(busy), 64'(0));
    repeat (3) tick();
    chk("zero_no_issue", 64'(ab_cnt - ab_base), 64'(0));
    chk("zero_done_count", 64'(done_cnt - done_base), 64'(1));

    // Backpressure: 16 elements, out_ready low
    clear();
    for (int i = 0; i < 16; i++) begin
      din[i]      = r2f(2.0 * real'(i + 1));
      exp_data[i] = r2f(real'(i + 1));
    end
    out_ready = 1'b0;
    start_vec(16, 32'h40000000);
    feed(16, 30);
    chk("bp_accepts", 64'(fed), 64'(8));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    chk("bp_no_pops", 64'(got_data.size()), 64'(0));
    out_ready = 1'b1;
    feed(16, 100);
    wait_done("bp", 100);
    check_results("bp", 16);

    // Simultaneous push/pop with out_ready toggling, credits tracked every cycle
    clear();
    for (int i = 0; i < 32; i++) begin
      din[i]      = r2f(2.0 * real'(i + 1));
      exp_data[i] = r2f(0.5 * real'(i + 1));
    end
    cred_base = tot_acc - tot_pop;
    cred_chk  = 1'b1;
    toggle    = 1'b1;
    start_vec(32, 32'h40800000);
    feed(32, 200);
    wait_done("tgl", 200);
    cred_chk  = 1'b0;
    toggle    = 1'b0;
    out_ready = 1'b1;
    check_results("tgl", 32);

    // Reset with three ops in flight; cfg_start held during FLUSH
    clear();
    for (int i = 0; i < 8; i++) din[i] = r2f(10.0 + 2.0 * real'(i));
    start_vec(8, 32'h40000000);
    feed(3, 20);
    chk("mid_fed", 64'(fed), 64'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_ab_valid", 64'(div_ab_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    cfg_start = 1'b1; cfg_len = 8'd5; cfg_divisor = 32'h3F800000;
    tick();
    chk("mid_flush_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mid_flush_ov%0d", i), 64'(out_valid), 64'(0));
    end
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("mid_post_ov%0d", i), 64'(out_valid), 64'(0));
    end
    chk("mid_idle_busy", 64'(busy), 64'(0));
    chk("mid_no_results", 64'(got_data.size()), 64'(0));
    chk("mid_no_done", 64'(done_cnt - done_base), 64'(0));

    clear();
    din[0] = 32'h41100000; din[1] = 32'h40400000;
    exp_data[0] = 32'h40400000; exp_data[1] = 32'h3F800000;
    start_vec(2, 32'h40400000);
    feed(2, 20);
    wait_done("post", 40);
    check_results("post", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
